// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Brief    : 32-bit signed/unsigned restoring divider, one quotient bit per
//            cycle, with divide-by-zero short path and pipeline-flush annul.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    localparam logic [4:0] C_LAST_ITER = 5'd31;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic        neg_quot_q;
    logic        neg_rem_q;

    logic [31:0] dividend_mag_d;
    logic [31:0] divisor_mag_d;
    logic [33:0] diff_d;
    logic [64:0] work_d;
    logic [31:0] quot_fix_d;
    logic [31:0] rem_fix_d;

    always_comb begin
        dividend_mag_d = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
        divisor_mag_d  = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;

        // Trial subtract on the left-shifted partial remainder; the borrow
        // (diff_d[33]) decides whether the subtraction is kept.
        diff_d = work_q[64:31] - {2'b00, divisor_q};
        if (diff_d[33]) begin
            work_d = {work_q[63:0], 1'b0};
        end else begin
            work_d = {diff_d[32:0], work_q[30:0], 1'b1};
        end

        quot_fix_d = neg_quot_q ? (32'd0 - work_d[31:0])  : work_d[31:0];
        rem_fix_d  = neg_rem_q  ? (32'd0 - work_d[63:32]) : work_d[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_o   <= 64'd0;
            ready_o    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_q <= S_DIVZERO;
                        end else begin
                            state_q    <= S_ON;
                            cnt_q      <= 5'd0;
                            work_q     <= {33'd0, dividend_mag_d};
                            divisor_q  <= divisor_mag_d;
                            neg_quot_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                            neg_rem_q  <= signed_div_i && opdata1_i[31];
                        end
                    end
                end
                S_DIVZERO: begin
                    result_o <= 64'd0;
                    if (annul_i) begin
                        state_q <= S_IDLE;
                        ready_o <= 1'b0;
                    end else begin
                        state_q <= S_END;
                        ready_o <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state_q  <= S_IDLE;
                        cnt_q    <= 5'd0;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 5'd1;
                        if (cnt_q == C_LAST_ITER) begin
                            state_q  <= S_END;
                            result_o <= {rem_fix_d, quot_fix_d};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                S_END: begin
                    // Result is held until EX releases start_i.
                    if (!start_i) begin
                        state_q  <= S_IDLE;
                        cnt_q    <= 5'd0;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed self-checking bench for div_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total  = 0;
    int passes = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble operands after acceptance, measure latency,
    // check hold-while-start, then release and check return to idle.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int n;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        step();
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        n = 0;
        while (!ready_o && n < 100) begin
            step();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " result"}, result_o, exp);
        step();
        chk({tag, " hold ready"}, {63'd0, ready_o}, 64'd1);
        chk({tag, " hold result"}, result_o, exp);
        start_i = 1'b0;
        step();
        chk({tag, " release ready"}, {63'd0, ready_o}, 64'd0);
        chk({tag, " release result"}, result_o, 64'd0);
    endtask

    initial begin
        bit seen_ready;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
        step();
        step();
        chk("reset ready", {63'd0, ready_o}, 64'd0);
        chk("reset result", result_o, 64'd0);
        rst = 1'b0;
        step();

        run_div("divu 100/7",      1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 32);
        run_div("div -7/2",        1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 32);
        run_div("div 7/-2",        1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 32);
        run_div("div -100/-7",     1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 32);
        run_div("divu FFFFFFF9/2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 32);
        run_div("div minint/-1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 32);
        run_div("divu FFFFFFFF/1", 1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 32);
        run_div("div by zero",     1'b1, 32'd1234,     32'd0,        64'd0,                  1);

        // start with annul in IDLE is ignored
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready_o) seen_ready = 1'b1;
        end
        chk("idle annul no ready", {63'd0, seen_ready}, 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        step();

        // annul at iteration 10
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        step();
        for (int i = 0; i < 9; i++) step();
        start_i = 1'b0; annul_i = 1'b1;
        step();
        annul_i = 1'b0;
        chk("annul ready", {63'd0, ready_o}, 64'd0);
        chk("annul result", result_o, 64'd0);
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready_o) seen_ready = 1'b1;
        end
        chk("annul never ready", {63'd0, seen_ready}, 64'd0);
        run_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32);

        // reset at iteration 20, start held high through reset
        signed_div_i = 1'b1; opdata1_i = 32'hFFFFFFF9; opdata2_i = 32'd2; start_i = 1'b1;
        step();
        for (int i = 0; i < 19; i++) step();
        rst = 1'b1;
        step();
        chk("midrst ready", {63'd0, ready_o}, 64'd0);
        chk("midrst result", result_o, 64'd0);
        step();
        chk("midrst hold ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        rst = 1'b0;
        step();
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready_o) seen_ready = 1'b1;
        end
        chk("post-reset idle", {63'd0, seen_ready}, 64'd0);
        run_div("divu 100/7 after reset", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the iteration count is fixed at 32.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned divide (DIVU); sampled at acceptance.
REQ-005 opdata1_i  input  32  dividend; sampled at acceptance.
REQ-006 opdata2_i  input  32  divisor; sampled at acceptance.
REQ-007 start_i  input  1  request from EX; held high while EX stalls, until EX sees ready_o.
REQ-008 annul_i  input  1  cancel request (pipeline flush); has priority over start_i.
REQ-009 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}; registered.
REQ-010 ready_o  output  1  result_o valid; registered.

Function
REQ-011 The FSM SHALL have four states: IDLE, DIVZERO, ON, END.
REQ-012 In IDLE with start_i=1 and annul_i=0 and opdata2_i=0: go to DIVZERO.
REQ-013 In IDLE with start_i=1, annul_i=0, opdata2_i!=0: go to ON; latch operands and signed flag; clear the iteration counter to 0.
REQ-014 Signed mode: operands SHALL be converted to magnitude (two's-complement negate if bit 31 set) before latching; unsigned mode latches them unchanged.
REQ-015 ON: one restoring shift-subtract iteration per cycle on a 65-bit partial-remainder/quotient register; counter increments by 1 per cycle.
REQ-016 On the edge completing iteration 32: go to END; register result_o; ready_o=1.
REQ-017 ready_o SHALL first be high exactly 32 cycles after the acceptance edge.
REQ-018 Signed fix-up at finish: quotient negated iff dividend sign != divisor sign; remainder negated iff dividend negative; the remainder takes the dividend's sign.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 (wrap, no exception).
REQ-020 DIVZERO: on the next edge go to END with result_o=0 and ready_o=1 (1-cycle latency, no exception).
REQ-021 ON or DIVZERO with annul_i=1: go to IDLE next edge; ready_o=0; result_o=0; no result produced.
REQ-022 END with start_i=1: remain in END; result_o and ready_o held stable.
REQ-023 END with start_i=0: go to IDLE; ready_o=0; result_o=0 on the same edge.
REQ-024 IDLE with start_i=1 and annul_i=1: request ignored; stay in IDLE.
REQ-025 Operand inputs changing after acceptance SHALL NOT affect the operation in progress.
REQ-026 A new request SHALL be accepted only from IDLE, i.e. no earlier than one cycle after start_i drops in END.

Reset
REQ-027 rst=1 on a rising edge: state=IDLE, counter=0, internal registers=0, result_o=0, ready_o=0.
REQ-028 Reset SHALL override annul_i and start_i, and SHALL abort any in-flight operation in any state.
REQ-029 After rst deasserts: the first accepted request SHALL behave as a normal request, with no residue from the aborted operation.

Verification
REQ-030 Unsigned 100/7 (signed_div_i=0) -> after 32 cycles ready_o=1, result_o=0x00000002_0000000E.
REQ-031 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7/-2 -> 0x00000001_FFFFFFFD.
REQ-032 Divisor 0 with start_i held -> ready_o=1 one cycle after acceptance, result_o=0; drop start_i -> IDLE, ready_o=0.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000; unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
REQ-034 annul_i pulsed at iteration 10 -> ready_o never rises; a following 9/3 request -> result_o=0x00000000_00000003 after 32 cycles.
REQ-035 rst asserted at iteration 20, then released -> outputs 0 during reset; the next 100/7 request completes correctly per REQ-030.
